// File: rtl/fifo_sync_ctrl_pkg.sv
// Shared defaults and helpers for the synchronous FIFO controller.
package fifo_sync_ctrl_pkg;

    // Default memory address width.
    localparam int unsigned DefAw = 4;

    // Default almost-empty level.
    localparam int unsigned DefAeLvl = 2;

    // Number of entries for a given address width.
    function automatic int unsigned fifo_depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    // Default almost-full level: two below full.
    function automatic int unsigned fifo_def_af_lvl(input int unsigned aw);
        return fifo_depth(aw) - 2;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping AW+1-bit FIFO pointer; the MSB is the wrap bit.
module fifo_ptr #(
    parameter int unsigned AW = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [AW-1:0] addr_o,
    output logic [AW:0]   ptr_nxt_o
);

    logic [AW:0] ptr_q;
    logic [AW:0] ptr_d;

    // Next pointer: clear wins over increment; wraps modulo 2^(AW+1).
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    // Pointer register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign addr_o    = ptr_q[AW-1:0];
    assign ptr_nxt_o = ptr_d;

endmodule

// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO controller driving a dual-port memory with FWFT reads.
module fifo_sync_ctrl
    import fifo_sync_ctrl_pkg::*;
#(
    parameter int unsigned AW     = DefAw,
    parameter int unsigned AF_LVL = fifo_def_af_lvl(AW),
    parameter int unsigned AE_LVL = DefAeLvl
) (
    input  logic          I_CLK,
    input  logic          I_RST_N,
    input  logic          I_CLR,
    input  logic          I_WR_EN,
    input  logic          I_RD_EN,
    output logic          O_MEM_WR_EN,
    output logic [AW-1:0] O_MEM_WR_ADDR,
    output logic [AW-1:0] O_MEM_RD_ADDR,
    output logic          O_FULL,
    output logic          O_EMPTY,
    output logic          O_AFULL,
    output logic          O_AEMPTY,
    output logic [AW:0]   O_COUNT,
    output logic          O_OVF,
    output logic          O_UDF
);

    localparam int unsigned Depth = fifo_depth(AW);
    localparam logic [AW:0] DepthC = (AW+1)'(Depth);
    localparam logic [AW:0] AfLvlC = (AW+1)'(AF_LVL);
    localparam logic [AW:0] AeLvlC = (AW+1)'(AE_LVL);

    // Reject threshold levels that would make a flag constant or meaningless.
    if (AF_LVL < 1 || AF_LVL > Depth) begin : g_bad_af_lvl
        $error("fifo_sync_ctrl: AF_LVL out of range 1..DEPTH");
    end
    if (AE_LVL > Depth - 1) begin : g_bad_ae_lvl
        $error("fifo_sync_ctrl: AE_LVL out of range 0..DEPTH-1");
    end

    logic          wr_ok;
    logic          rd_ok;
    logic [AW:0]   wr_ptr_nxt;
    logic [AW:0]   rd_ptr_nxt;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          afull_q, afull_d;
    logic          aempty_q, aempty_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    fifo_ptr #(
        .AW (AW)
    ) u_wr_ptr (
        .clk_i     (I_CLK),
        .rst_ni    (I_RST_N),
        .clr_i     (I_CLR),
        .inc_i     (wr_ok),
        .addr_o    (O_MEM_WR_ADDR),
        .ptr_nxt_o (wr_ptr_nxt)
    );

    fifo_ptr #(
        .AW (AW)
    ) u_rd_ptr (
        .clk_i     (I_CLK),
        .rst_ni    (I_RST_N),
        .clr_i     (I_CLR),
        .inc_i     (rd_ok),
        .addr_o    (O_MEM_RD_ADDR),
        .ptr_nxt_o (rd_ptr_nxt)
    );

    // Accept decisions, next occupancy and next flag/error state.
    always_comb begin
        // Reset gating keeps the memory write enable low throughout reset.
        wr_ok = I_RST_N & I_WR_EN & ~full_q & ~I_CLR;
        rd_ok = I_RST_N & I_RD_EN & ~empty_q & ~I_CLR;

        // Pointer difference over AW+1 bits equals count + wr_ok - rd_ok.
        count_d  = wr_ptr_nxt - rd_ptr_nxt;
        full_d   = (count_d == DepthC);
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= AfLvlC);
        aempty_d = (count_d <= AeLvlC);

        if (I_CLR) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end else begin
            ovf_d = ovf_q | (I_WR_EN & full_q);
            udf_d = udf_q | (I_RD_EN & empty_q);
        end
    end

    // Occupancy, flag and sticky error registers.
    always_ff @(posedge I_CLK) begin
        if (!I_RST_N) begin
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign O_MEM_WR_EN = wr_ok;
    assign O_COUNT     = count_q;
    assign O_FULL      = full_q;
    assign O_EMPTY     = empty_q;
    assign O_AFULL     = afull_q;
    assign O_AEMPTY    = aempty_q;
    assign O_OVF       = ovf_q;
    assign O_UDF       = udf_q;

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Directed self-checking bench for fifo_sync_ctrl with a behavioural memory.
module tb_fifo_sync_ctrl;

    localparam int unsigned AW = 4;

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic          wr_en;
    logic          rd_en;
    logic [7:0]    wdata;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [AW-1:0] mem_rd_addr;
    logic          full;
    logic          empty;
    logic          afull;
    logic          aempty;
    logic [AW:0]   count;
    logic          ovf;
    logic          udf;
    logic [7:0]    mem [16];
    logic [7:0]    rdata;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    fifo_sync_ctrl #(
        .AW     (AW),
        .AF_LVL (14),
        .AE_LVL (2)
    ) dut (
        .I_CLK         (clk),
        .I_RST_N       (rst_n),
        .I_CLR         (clr),
        .I_WR_EN       (wr_en),
        .I_RD_EN       (rd_en),
        .O_MEM_WR_EN   (mem_wr_en),
        .O_MEM_WR_ADDR (mem_wr_addr),
        .O_MEM_RD_ADDR (mem_rd_addr),
        .O_FULL        (full),
        .O_EMPTY       (empty),
        .O_AFULL       (afull),
        .O_AEMPTY      (aempty),
        .O_COUNT       (count),
        .O_OVF         (ovf),
        .O_UDF         (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dual-port memory: synchronous write, asynchronous read.
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_wr_addr] <= wdata;
    end
    assign rdata = mem[mem_rd_addr];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; outputs settle 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0;
        rd_en = 1'b0;
        clr   = 1'b0;
    endtask

    initial begin
        int unsigned n;
        logic [3:0] ea;
        rst_n = 1'b0;
        clr   = 1'b0;
        wr_en = 1'b1;
        rd_en = 1'b0;
        wdata = 8'h00;
        #1;

        // Reset with a write request pending.
        check("rst_wr_en_comb", {31'd0, mem_wr_en}, 32'd0);
        tick();
        tick();
        check("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_count", {27'd0, count}, 32'd0);
        check("rst_aempty", {31'd0, aempty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_afull", {31'd0, afull}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_udf", {31'd0, udf}, 32'd0);
        check("rst_wr_addr", {28'd0, mem_wr_addr}, 32'd0);
        check("rst_rd_addr", {28'd0, mem_rd_addr}, 32'd0);
        idle();
        rst_n = 1'b1;
        tick();

        // Fill with 0x00..0x0F.
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1;
            wdata = 8'(i);
            #1;
            check("fill_wr_en", {31'd0, mem_wr_en}, 32'd1);
            check("fill_wr_addr", {28'd0, mem_wr_addr}, 32'(i));
            tick();
            check("fill_count", {27'd0, count}, 32'(i + 1));
            check("fill_afull", {31'd0, afull}, (i + 1 >= 14) ? 32'd1 : 32'd0);
            check("fill_full", {31'd0, full}, (i + 1 == 16) ? 32'd1 : 32'd0);
            check("fill_aempty", {31'd0, aempty}, (i + 1 <= 2) ? 32'd1 : 32'd0);
            check("fill_empty", {31'd0, empty}, 32'd0);
        end

        // Full: simultaneous read and write; write dropped, read accepted.
        wr_en = 1'b1;
        rd_en = 1'b1;
        wdata = 8'hEE;
        #1;
        check("ovf_wr_en", {31'd0, mem_wr_en}, 32'd0);
        check("ovf_head", {24'd0, rdata}, 32'h00);
        tick();
        idle();
        check("ovf_count", {27'd0, count}, 32'd15);
        check("ovf_flag", {31'd0, ovf}, 32'd1);
        check("ovf_full", {31'd0, full}, 32'd0);
        check("ovf_afull", {31'd0, afull}, 32'd1);

        // Drain the remaining 15 entries in order.
        for (int j = 1; j < 16; j++) begin
            rd_en = 1'b1;
            #1;
            check("drain_data", {24'd0, rdata}, 32'(j));
            tick();
            check("drain_count", {27'd0, count}, 32'(15 - j));
            check("drain_aempty", {31'd0, aempty}, (15 - j <= 2) ? 32'd1 : 32'd0);
            check("drain_empty", {31'd0, empty}, (j == 15) ? 32'd1 : 32'd0);
        end
        idle();
        tick();
        check("ovf_sticky", {31'd0, ovf}, 32'd1);
        check("drain_rd_addr", {28'd0, mem_rd_addr}, 32'd0);

        // Clear pulse drops the overflow flag.
        clr = 1'b1;
        tick();
        idle();
        check("clr_ovf", {31'd0, ovf}, 32'd0);
        check("clr_count", {27'd0, count}, 32'd0);
        check("clr_empty", {31'd0, empty}, 32'd1);

        // Underflow: read while empty is ignored.
        rd_en = 1'b1;
        tick();
        idle();
        check("udf_flag", {31'd0, udf}, 32'd1);
        check("udf_rd_addr", {28'd0, mem_rd_addr}, 32'd0);
        check("udf_count", {27'd0, count}, 32'd0);

        // Read plus write while empty: only the write lands.
        rd_en = 1'b1;
        wr_en = 1'b1;
        wdata = 8'h55;
        #1;
        check("udfw_wr_en", {31'd0, mem_wr_en}, 32'd1);
        tick();
        idle();
        check("udfw_count", {27'd0, count}, 32'd1);
        check("udfw_empty", {31'd0, empty}, 32'd0);
        check("udfw_rd_addr", {28'd0, mem_rd_addr}, 32'd0);
        check("udfw_head", {24'd0, rdata}, 32'h55);
        exp_q.push_back(8'h55);

        // Top up to five entries for the wrap test.
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1;
            wdata = 8'h60 + 8'(i);
            exp_q.push_back(wdata);
            tick();
        end
        idle();
        check("pre_wrap_count", {27'd0, count}, 32'd5);

        // Simultaneous read/write across address wrap.
        for (int k = 0; k < 40; k++) begin
            wr_en = 1'b1;
            rd_en = 1'b1;
            wdata = 8'h70 + 8'(k);
            #1;
            ea = 4'(k);
            check("wrap_rd_addr", {28'd0, mem_rd_addr}, {28'd0, ea});
            ea = 4'(k + 5);
            check("wrap_wr_addr", {28'd0, mem_wr_addr}, {28'd0, ea});
            check("wrap_data", {24'd0, rdata}, {24'd0, exp_q.pop_front()});
            exp_q.push_back(wdata);
            tick();
            check("wrap_count", {27'd0, count}, 32'd5);
        end
        idle();

        // Grow to nine entries, then clear with a write pending.
        n = 5;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1;
            wdata = 8'hC0 + 8'(i);
            tick();
            n++;
        end
        idle();
        check("pre_clr_count", {27'd0, count}, n);
        clr   = 1'b1;
        wr_en = 1'b1;
        wdata = 8'hDD;
        #1;
        check("clr_wr_en", {31'd0, mem_wr_en}, 32'd0);
        tick();
        idle();
        check("mclr_count", {27'd0, count}, 32'd0);
        check("mclr_empty", {31'd0, empty}, 32'd1);
        check("mclr_udf", {31'd0, udf}, 32'd0);
        check("mclr_wr_addr", {28'd0, mem_wr_addr}, 32'd0);
        check("mclr_rd_addr", {28'd0, mem_rd_addr}, 32'd0);

        // First write after the clear becomes the head.
        wr_en = 1'b1;
        wdata = 8'hAB;
        tick();
        idle();
        check("post_clr_empty", {31'd0, empty}, 32'd0);
        check("post_clr_count", {27'd0, count}, 32'd1);
        check("post_clr_head", {24'd0, rdata}, 32'hAB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
